// File: rtl/lab_pkg.sv
// Shared lab types and constants: draw-engine states, octant masks and the
// 3-bit palette used by every drawing block.
package lab_pkg;

  typedef enum logic [2:0] {
    ARC_IDLE,
    ARC_LOAD,
    ARC_SCAN,
    ARC_STEP,
    ARC_DONE
  } arc_state_t;

  localparam logic [7:0] ARC_OCT_ALL = 8'hFF;

  localparam logic [2:0] COL_BLACK = 3'd0;
  localparam logic [2:0] COL_BLUE  = 3'd1;
  localparam logic [2:0] COL_GREEN = 3'd2;
  localparam logic [2:0] COL_RED   = 3'd4;
  localparam logic [2:0] COL_WHITE = 3'd7;

endpackage

// File: rtl/arc_octant_map.sv
// Maps an octant index and the current midpoint offsets onto a screen pixel,
// flagging whether that pixel lies inside the visible area.
module arc_octant_map #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int RW = 8,
  parameter int PW = 10
) (
  input  logic [2:0]           oct,
  input  logic signed [RW:0]   dx,
  input  logic signed [RW:0]   dy,
  input  logic [XW-1:0]        cx,
  input  logic [YW-1:0]        cy,
  output logic [XW-1:0]        pix_x,
  output logic [YW-1:0]        pix_y,
  output logic                 on_screen
);

  localparam logic signed [PW-1:0] X_LIM = PW'(SCREEN_W);
  localparam logic signed [PW-1:0] Y_LIM = PW'(SCREEN_H);

  logic signed [PW-1:0] cxs, cys, dxs, dys, px, py;

  assign cxs = {{(PW-XW){1'b0}}, cx};
  assign cys = {{(PW-YW){1'b0}}, cy};
  assign dxs = {{(PW-RW-1){dx[RW]}}, dx};
  assign dys = {{(PW-RW-1){dy[RW]}}, dy};

  // Octant 1 is index 0; each octant reflects (dx,dy) about the centre.
  always_comb begin
    px = cxs;
    py = cys;
    case (oct)
      3'd0: begin px = cxs + dxs; py = cys + dys; end
      3'd1: begin px = cxs + dys; py = cys + dxs; end
      3'd2: begin px = cxs - dys; py = cys + dxs; end
      3'd3: begin px = cxs - dxs; py = cys + dys; end
      3'd4: begin px = cxs - dxs; py = cys - dys; end
      3'd5: begin px = cxs - dys; py = cys - dxs; end
      3'd6: begin px = cxs + dys; py = cys - dxs; end
      default: begin px = cxs + dxs; py = cys - dys; end
    endcase
  end

  assign on_screen = (px >= 0) && (px < X_LIM) && (py >= 0) && (py < Y_LIM);
  assign pix_x = px[XW-1:0];
  assign pix_y = py[YW-1:0];

endmodule

// File: rtl/arc_engine.sv
// Midpoint-circle arc drawer: walks the offsets of one octant and mirrors each
// point into the octants enabled by the mask, with a valid/ready pixel port.
module arc_engine
  import lab_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int RW = 8,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [XW-1:0] centre_x,
  input  logic [YW-1:0] centre_y,
  input  logic [RW-1:0] radius,
  input  logic [CW-1:0] colour,
  input  logic [7:0]    octant_mask,
  input  logic          plot_ready,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [CW-1:0] vga_colour,
  output logic          vga_plot,
  output logic          done
);

  localparam int PW = ((XW > YW) ? XW : YW) + 2;
  localparam logic signed [RW+2:0] CRIT_ZERO = (RW+3)'(0);
  localparam logic signed [RW+2:0] CRIT_ONE  = (RW+3)'(1);
  localparam logic signed [RW:0]   OFF_ONE   = (RW+1)'(1);

  arc_state_t state, state_nxt;

  logic [2:0]           oct;
  logic [XW-1:0]        cx;
  logic [YW-1:0]        cy;
  logic [CW-1:0]        col;
  logic [7:0]           mask;
  logic signed [RW:0]   off_x, off_y, x_nxt, y_nxt;
  logic signed [RW+2:0] crit, crit_nxt;
  logic [XW-1:0]        pix_x;
  logic [YW-1:0]        pix_y;
  logic                 on_screen;
  logic                 advance;

  arc_octant_map #(
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H),
    .XW(XW), .YW(YW), .RW(RW), .PW(PW)
  ) u_map (
    .oct(oct), .dx(off_x), .dy(off_y), .cx(cx), .cy(cy),
    .pix_x(pix_x), .pix_y(pix_y), .on_screen(on_screen)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ARC_IDLE;
    else        state <= state_nxt;
  end

  // Offsets are one bit wider than the radius so x may go below zero on the
  // final step (r=0) and still terminate the loop correctly.
  always_comb begin
    y_nxt    = off_y + OFF_ONE;
    x_nxt    = off_x;
    crit_nxt = crit + ({{2{y_nxt[RW]}}, y_nxt} <<< 1) + CRIT_ONE;
    if (crit > CRIT_ZERO) begin
      x_nxt    = off_x - OFF_ONE;
      crit_nxt = crit + (({{2{y_nxt[RW]}}, y_nxt} - {{2{x_nxt[RW]}}, x_nxt}) <<< 1) + CRIT_ONE;
    end
  end

  always_comb begin
    state_nxt = state;
    vga_plot  = 1'b0;
    vga_x     = '0;
    vga_y     = '0;
    done      = 1'b0;
    advance   = 1'b0;
    case (state)
      ARC_IDLE: if (start) state_nxt = ARC_LOAD;
      ARC_LOAD: state_nxt = ARC_SCAN;
      ARC_SCAN: begin
        vga_plot = mask[oct] && on_screen;
        vga_x    = pix_x;
        vga_y    = pix_y;
        advance  = !vga_plot || plot_ready;
        if (advance && oct == 3'd7) state_nxt = ARC_STEP;
      end
      ARC_STEP: state_nxt = (y_nxt <= x_nxt) ? ARC_SCAN : ARC_DONE;
      ARC_DONE: begin
        done = 1'b1;
        if (!start) state_nxt = ARC_IDLE;
      end
      default: state_nxt = ARC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oct   <= '0;
      cx    <= '0;
      cy    <= '0;
      col   <= '0;
      mask  <= '0;
      off_x <= '0;
      off_y <= '0;
      crit  <= '0;
    end else begin
      case (state)
        ARC_LOAD: begin
          cx    <= centre_x;
          cy    <= centre_y;
          col   <= colour;
          mask  <= octant_mask;
          off_x <= {1'b0, radius};
          off_y <= '0;
          crit  <= CRIT_ONE - {3'b000, radius};
          oct   <= '0;
        end
        ARC_SCAN: if (advance) oct <= oct + 3'd1;
        ARC_STEP: begin
          off_x <= x_nxt;
          off_y <= y_nxt;
          crit  <= crit_nxt;
        end
        default: ;
      endcase
    end
  end

  assign vga_colour = col;

endmodule

// File: tb/tb_arc_engine.sv
// Scoreboard bench for arc_engine: stimulus pushes expected pixels, a negedge
// monitor pops and compares every accepted plot.
module tb_arc_engine;
  import lab_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] centre_x = '0;
  logic [6:0] centre_y = '0;
  logic [7:0] radius = '0;
  logic [2:0] colour = '0;
  logic [7:0] octant_mask = '0;
  logic       plot_ready = 1'b1;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       done;

  arc_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
    .colour(colour), .octant_mask(octant_mask), .plot_ready(plot_ready),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_x[$];
  int exp_y[$];
  int exp_c[$];
  int plot_count = 0;
  bit got_first = 1'b0;
  int first_x = 0;
  int first_y = 0;
  bit chk_quad = 1'b0;
  int quad_cx = 0;
  int quad_cy = 0;

  task automatic check_output(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic push_px(input int x, input int y, input int c);
    exp_x.push_back(x);
    exp_y.push_back(y);
    exp_c.push_back(c);
  endtask

  task automatic flush_queue();
    exp_x.delete();
    exp_y.delete();
    exp_c.delete();
  endtask

  // Reference midpoint walk on plain integers; emits clipped, masked pixels.
  task automatic model_draw(input int cx, input int cy, input int r, input logic [7:0] mask,
                            input int c, output int iters, output int nplots);
    int x, y, d, px, py;
    x = r; y = 0; d = 1 - r; iters = 0; nplots = 0;
    do begin
      iters++;
      for (int o = 0; o < 8; o++) begin
        case (o)
          0: begin px = cx + x; py = cy + y; end
          1: begin px = cx + y; py = cy + x; end
          2: begin px = cx - y; py = cy + x; end
          3: begin px = cx - x; py = cy + y; end
          4: begin px = cx - x; py = cy - y; end
          5: begin px = cx - y; py = cy - x; end
          6: begin px = cx + y; py = cy - x; end
          default: begin px = cx + x; py = cy - y; end
        endcase
        if (mask[o] && px >= 0 && px < 160 && py >= 0 && py < 120) begin
          push_px(px, py, c);
          nplots++;
        end
      end
      y++;
      if (d <= 0) d += 2 * y + 1;
      else begin
        x--;
        d += 2 * (y - x) + 1;
      end
    end while (y <= x);
  endtask

  always @(negedge clk) begin
    int ex, ey, ec;
    if (rst_n && vga_plot && plot_ready) begin
      plot_count++;
      if (!got_first) begin
        got_first = 1'b1;
        first_x = int'(vga_x);
        first_y = int'(vga_y);
      end
      if (chk_quad) begin
        check_output("quadrant x<=cx", int'(int'(vga_x) <= quad_cx), 1);
        check_output("quadrant y<=cy", int'(int'(vga_y) <= quad_cy), 1);
      end
      if (exp_x.size() == 0) begin
        check_output("unexpected plot", 1, 0);
      end else begin
        ex = exp_x.pop_front();
        ey = exp_y.pop_front();
        ec = exp_c.pop_front();
        check_output("pixel x", int'(vga_x), ex);
        check_output("pixel y", int'(vga_y), ey);
        check_output("pixel colour", int'(vga_colour), ec);
      end
    end
  end

  task automatic apply_stimulus(input int cx, input int cy, input int r, input logic [7:0] mask,
                                input int c, input int stall_n, input int exp_done,
                                input string name);
    int cyc, stalls, hx, hy;
    bit held_chk;
    plot_count = 0;
    got_first = 1'b0;
    @(posedge clk); #1;
    centre_x = 8'(cx);
    centre_y = 7'(cy);
    radius = 8'(r);
    colour = 3'(c);
    octant_mask = mask;
    start = 1'b1;
    plot_ready = 1'b1;
    @(posedge clk); #1;
    cyc = 1; stalls = 0; held_chk = 1'b0; hx = 0; hy = 0;
    while (!done && cyc < 3000) begin
      if (cyc == 2) begin
        centre_x = 8'd3;
        centre_y = 7'd5;
        radius = 8'd77;
        colour = ~colour;
        octant_mask = ~octant_mask;
      end
      plot_ready = 1'b1;
      if (vga_plot && stalls < stall_n) begin
        if (stalls == 0) begin
          hx = int'(vga_x);
          hy = int'(vga_y);
        end else begin
          check_output({name, " stall x"}, int'(vga_x), hx);
          check_output({name, " stall y"}, int'(vga_y), hy);
          check_output({name, " stall plot"}, int'(vga_plot), 1);
        end
        plot_ready = 1'b0;
        stalls++;
      end else if (stall_n > 0 && stalls == stall_n && !held_chk) begin
        held_chk = 1'b1;
        check_output({name, " release x"}, int'(vga_x), hx);
        check_output({name, " release y"}, int'(vga_y), hy);
        check_output({name, " release plot"}, int'(vga_plot), 1);
      end
      @(posedge clk); #1;
      cyc++;
    end
    plot_ready = 1'b1;
    check_output({name, " done cycle"}, cyc, exp_done);
    repeat (2) begin
      @(posedge clk); #1;
      check_output({name, " done held"}, int'(done), 1);
    end
    start = 1'b0;
    @(posedge clk); #1;
    check_output({name, " done dropped"}, int'(done), 0);
    check_output({name, " queue drained"}, exp_x.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int it, np;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset plot", int'(vga_plot), 0);
    check_output("reset done", int'(done), 0);
    check_output("reset x", int'(vga_x), 0);
    check_output("reset y", int'(vga_y), 0);
    check_output("reset colour", int'(vga_colour), 0);
    rst_n = 1'b1;

    repeat (8) push_px(80, 60, int'(COL_RED));
    apply_stimulus(80, 60, 0, ARC_OCT_ALL, int'(COL_RED), 0, 11, "r0");
    check_output("r0 plot count", plot_count, 8);

    push_px(81, 60, int'(COL_GREEN));
    push_px(81, 61, int'(COL_GREEN));
    apply_stimulus(80, 60, 1, 8'h01, int'(COL_GREEN), 0, 20, "r1");
    check_output("r1 plot count", plot_count, 2);

    model_draw(0, 0, 10, ARC_OCT_ALL, int'(COL_BLUE), it, np);
    apply_stimulus(0, 0, 10, ARC_OCT_ALL, int'(COL_BLUE), 0, 2 + 9 * it, "corner");
    check_output("corner first seen", int'(got_first), 1);
    check_output("corner first x", first_x, 10);
    check_output("corner first y", first_y, 0);
    check_output("corner plot count", plot_count, np);

    chk_quad = 1'b1;
    quad_cx = 80;
    quad_cy = 60;
    model_draw(80, 60, 5, 8'h30, int'(COL_WHITE), it, np);
    apply_stimulus(80, 60, 5, 8'h30, int'(COL_WHITE), 0, 2 + 9 * it, "oct56");
    chk_quad = 1'b0;
    check_output("oct56 plot count", plot_count, np);

    model_draw(80, 60, 4, ARC_OCT_ALL, int'(COL_RED), it, np);
    apply_stimulus(80, 60, 4, ARC_OCT_ALL, int'(COL_RED), 5, 43, "stall");

    model_draw(80, 60, 20, ARC_OCT_ALL, int'(COL_GREEN), it, np);
    @(posedge clk); #1;
    centre_x = 8'd80;
    centre_y = 7'd60;
    radius = 8'd20;
    colour = COL_GREEN;
    octant_mask = ARC_OCT_ALL;
    start = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    check_output("midscan plot", int'(vga_plot), 1);
    check_output("midscan x", int'(vga_x), 60);
    rst_n = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    check_output("abort plot", int'(vga_plot), 0);
    check_output("abort done", int'(done), 0);
    rst_n = 1'b1;
    flush_queue();
    repeat (3) begin
      @(posedge clk); #1;
      check_output("idle after abort", int'(vga_plot), 0);
    end

    model_draw(80, 60, 3, ARC_OCT_ALL, int'(COL_BLUE), it, np);
    apply_stimulus(80, 60, 3, ARC_OCT_ALL, int'(COL_BLUE), 0, 2 + 9 * it, "restart");
    check_output("restart plot count", plot_count, np);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
